// File: rtl/pixel_stream_if.sv
// Byte stream from the frame-buffer reader to the pixel processor:
// valid/ready handshake carrying the byte, its raster position and frame/line markers.
interface pixel_stream_if #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 128
);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             sof;
  logic             eol;
  logic             eof;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [1:0]       out_chan;

  modport master (
    output out_valid, out_byte, sof, eol, eof, out_row, out_col, out_chan,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_byte, sof, eol, eof, out_row, out_col, out_chan,
    output out_ready
  );
endinterface

// File: rtl/pixel_stream_source.sv
// Frame-buffer reader: host preloads one frame, then start streams it out in raster
// order, one byte per cycle, through a 2-entry prefetch buffer over the RAM latency.
module pixel_stream_source #(
  parameter int IMG_WIDTH       = 256,
  parameter int IMG_HEIGHT      = 128,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int ADDR_W          = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  pixel_stream_if.master    px
);
  localparam int DATA_W = 8;
  localparam int FRAME  = IMG_WIDTH * IMG_HEIGHT * BYTES_PER_PIXEL;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [ADDR_W:0]  FRAME_SZ  = (ADDR_W+1)'(FRAME);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [1:0]       CHAN_LAST = 2'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FINISH} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [0:FRAME-1];
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              rd_issue;
  logic              start_ok;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] buf_p2 [0:1];
  logic              buf_wp;
  logic              buf_rp;
  logic [1:0]        buf_cnt;
  logic [1:0]        occ;
  logic              vld_p2;
  logic              pop;
  logic              sof_c;
  logic              eol_c;
  logic              eof_c;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [1:0]        chan_q;

  assign start_ok = start && (state == IDLE || state == FINISH);
  assign vld_p2   = (buf_cnt != 2'd0);
  assign pop      = vld_p2 && px.out_ready;
  // Bytes buffered plus the one in flight from RAM never exceed the two buffer slots.
  assign occ      = buf_cnt + {1'b0, vld_p1};
  assign rd_issue = (state == PRIME || state == STREAM) && (rd_ptr < FRAME_SZ) &&
                    ((occ < 2'd2) || (occ == 2'd2 && pop));
  assign rd_en    = start_ok || rd_issue;
  assign rd_addr  = start_ok ? '0 : rd_ptr[ADDR_W-1:0];

  assign sof_c = (row_q == '0) && (col_q == '0) && (chan_q == 2'd0);
  assign eol_c = (col_q == COL_LAST) && (chan_q == CHAN_LAST);
  assign eof_c = eol_c && (row_q == ROW_LAST);

  // p0 -> p1: frame RAM, host writes only while idle
  always_ff @(posedge clk) begin
    if (load_en && !busy && ({1'b0, load_addr} < FRAME_SZ))
      mem[load_addr] <= load_data;
    if (rd_en)
      rd_data_p1 <= mem[rd_addr];
  end

  // p1 -> p2: prefetch buffer absorbs the read latency under backpressure
  always_ff @(posedge clk) begin
    if (vld_p1)
      buf_p2[buf_wp] <= rd_data_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_ptr  <= '0;
      vld_p1  <= 1'b0;
      buf_wp  <= 1'b0;
      buf_rp  <= 1'b0;
      buf_cnt <= 2'd0;
      row_q   <= '0;
      col_q   <= '0;
      chan_q  <= 2'd0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en)
        rd_ptr <= start_ok ? (ADDR_W+1)'(1) : rd_ptr + (ADDR_W+1)'(1);
      if (vld_p1)
        buf_wp <= ~buf_wp;
      if (pop)
        buf_rp <= ~buf_rp;
      buf_cnt <= buf_cnt + {1'b0, vld_p1} - {1'b0, pop};

      // Position of the byte at the head of the buffer; wraps to 0 after the last byte.
      if (pop) begin
        if (chan_q == CHAN_LAST) begin
          chan_q <= 2'd0;
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end else begin
          chan_q <= chan_q + 2'd1;
        end
      end

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= PRIME;
            busy  <= 1'b1;
          end
        end
        PRIME: state <= STREAM;
        STREAM: begin
          if (pop && eof_c) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          if (start) begin
            state <= PRIME;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign px.out_valid = vld_p2;
  assign px.out_byte  = vld_p2 ? buf_p2[buf_rp] : '0;
  assign px.sof       = vld_p2 && sof_c;
  assign px.eol       = vld_p2 && eol_c;
  assign px.eof       = vld_p2 && eof_c;
  assign px.out_row   = row_q;
  assign px.out_col   = col_q;
  assign px.out_chan  = chan_q;
endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Frame-buffer reader that produces the byte stream consumed by the point-operation pixel processor. Byte order is raster order with interleaved channels.
- A host side preloads one frame of IMG_WIDTH x IMG_HEIGHT x BYTES_PER_PIXEL bytes through a write port.
- On start, the block streams the frame out one byte per cycle under valid/ready handshake, with frame and line markers.
- It replaces the file-driven byte feed with synthesizable RTL.

Parameters:
- IMG_WIDTH, 256, pixels per row.
- IMG_HEIGHT, 128, rows per frame.
- BYTES_PER_PIXEL, 3, bytes per pixel, interleaved.
- ADDR_W, 17, address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT*BYTES_PER_PIXEL (98304 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_en  in  1  write strobe into frame RAM.
- load_addr  in  ADDR_W  write byte address.
- load_data  in  8  write byte.
- start  in  1  begin streaming one frame.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last byte is accepted.
- out_valid  out  1  out_byte and markers are valid.
- out_ready  in  1  downstream accepts the byte when high with out_valid.
- out_byte  out  8  pixel byte.
- sof  out  1  qualifies the first byte of the frame.
- eol  out  1  qualifies the last byte of each row.
- eof  out  1  qualifies the last byte of the frame.
- out_row  out  clog2(IMG_HEIGHT)  row of current byte.
- out_col  out  clog2(IMG_WIDTH)  column of current byte.
- out_chan  out  2  channel index 0..BYTES_PER_PIXEL-1.

Behaviour:
- Reset values:
  - busy=0, done=0, out_valid=0, sof=eol=eof=0.
  - out_byte=0, out_row=0, out_col=0, out_chan=0.
  - Read and output pointers are cleared.
  - Frame RAM contents are NOT cleared by rst.
- Frame RAM:
  - Single-clock, synchronous write and synchronous read, 1-cycle read latency.
  - load_en writes only when busy=0; load_en while busy=1 is ignored.
  - Writes with load_addr >= frame size are ignored.
- FSM states are IDLE, PRIME, STREAM, FINISH.
  - IDLE: start=1 -> PRIME, busy=1, read address 0 issued. start in any other state is ignored.
  - PRIME: wait for the read latency. Then -> STREAM with out_valid=1 presenting byte 0.
  - The first out_valid rises 2 cycles after the start cycle.
  - STREAM: a transfer occurs on a cycle with out_valid&&out_ready.
  - FINISH: entered after the eof byte transfers; asserts done=1 for exactly one cycle, busy=0, out_valid=0, then -> IDLE.
  - start sampled during the FINISH (done) cycle is accepted, allowing back-to-back frames.
- Throughput: with out_ready held high, one byte transfers per cycle with no bubbles. Implement with a 2-entry output skid/prefetch buffer over the 1-cycle RAM latency.
- Backpressure:
  - While out_valid=1 and out_ready=0, hold out_byte, sof, eol, eof, out_row, out_col and out_chan stable.
  - out_valid never drops before transfer.
- Counters:
  - out_chan increments per transfer and wraps at BYTES_PER_PIXEL-1 to 0, incrementing out_col.
  - out_col wraps at IMG_WIDTH-1 to 0, incrementing out_row.
  - out_row reaches IMG_HEIGHT-1 on the final row.
- Markers:
  - sof = (row==0 && col==0 && chan==0).
  - eol = (col==IMG_WIDTH-1 && chan==BYTES_PER_PIXEL-1).
  - eof = eol && row==IMG_HEIGHT-1.
  - All markers are gated by out_valid.
- Byte address equals ((row*IMG_WIDTH)+col)*BYTES_PER_PIXEL+chan. Implement it as a linear counter, not a multiplier.
- Reset mid-frame: on the cycle after rst, out_valid=0, busy=0, state=IDLE, and no done pulse. A subsequent start restarts at byte 0.
- out_ready high while out_valid low has no effect.

Test Plan:
- Load addr n with n[7:0] for the full frame, start, hold out_ready=1. Expect:
  - first out_valid 2 cycles after start;
  - 98304 consecutive transfers with out_byte = index mod 256;
  - sof on transfer 0, eol every 768th transfer (128 total);
  - eof on transfer 98303, done pulse 1 cycle later, busy low.
- Random backpressure (out_ready toggled pseudo-randomly, 50%). Expect:
  - byte sequence identical to the previous scenario;
  - outputs stable across every stalled cycle;
  - no byte dropped or duplicated.
- Use IMG_WIDTH=4, IMG_HEIGHT=2, BPP=3. Check out_row/out_col/out_chan:
  - (0,0,0) through (0,3,2), eol at transfer 11;
  - then (1,0,0) through (1,3,2), eof at transfer 23.
- Assert start during streaming and at the done cycle. Expect:
  - start during streaming is ignored, so the frame count is unchanged;
  - start at the done cycle begins a second frame whose first out_valid appears 2 cycles later with sof=1.
- Assert rst at transfer 500. Expect:
  - next cycle out_valid=0, busy=0, done never pulses;
  - re-start yields byte 0 with sof=1;
  - RAM contents are preserved: byte 500 still reads 500 mod 256.
- Issue load_en with addr 5 and data 8'hAA while busy. Expect byte 5 still reads its original value in the next frame.
